// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered 3-bit add unit between requesters A and B.
// Each accepted request takes IDLE -> EXEC -> RESP; results are tagged with the owner.
module adder_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic [2:0] op1_a,
  input  logic [2:0] op2_a,
  input  logic       mode_a,
  input  logic       req_b,
  input  logic [2:0] op1_b,
  input  logic [2:0] op2_b,
  input  logic       mode_b,
  output logic       grant_a,
  output logic       grant_b,
  output logic       valid,
  output logic [2:0] result,
  output logic       overflow,
  output logic       owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_r;
  logic       ptr_r;
  logic [2:0] op1_r;
  logic [2:0] op2_r;
  logic       mode_r;
  logic       win_b_s;
  logic [3:0] add_s;

  // Returns {overflow, sum[2:0]}; signed overflow is carry-out XOR carry into the sign bit.
  function automatic logic [3:0] add_ovf(input logic [2:0] a, input logic [2:0] b,
                                         input logic m);
    logic [3:0] sum;
    logic [2:0] low;
    logic       ovf;
    sum = {1'b0, a} + {1'b0, b};
    low = {1'b0, a[1:0]} + {1'b0, b[1:0]};
    if (m) begin
      ovf = sum[3] ^ low[2];
    end else begin
      ovf = sum[3];
    end
    return {ovf, sum[2:0]};
  endfunction

  // Winner selection: single requester wins, contention goes to the one not last served.
  always_comb begin
    win_b_s = 1'b0;
    if (req_a && req_b) begin
      win_b_s = ~ptr_r;
    end else if (req_b) begin
      win_b_s = 1'b1;
    end else begin
      win_b_s = 1'b0;
    end
  end

  // Add unit operating on the captured operands.
  always_comb begin
    add_s = add_ovf(op1_r, op2_r, mode_r);
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      ptr_r    <= 1'b1;
      op1_r    <= 3'd0;
      op2_r    <= 3'd0;
      mode_r   <= 1'b0;
      grant_a  <= 1'b0;
      grant_b  <= 1'b0;
      valid    <= 1'b0;
      result   <= 3'd0;
      overflow <= 1'b0;
      owner    <= 1'b0;
    end else begin
      grant_a <= 1'b0;
      grant_b <= 1'b0;
      valid   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_a || req_b) begin
            grant_a <= ~win_b_s;
            grant_b <= win_b_s;
            owner   <= win_b_s;
            ptr_r   <= win_b_s;
            op1_r   <= win_b_s ? op1_b  : op1_a;
            op2_r   <= win_b_s ? op2_b  : op2_a;
            mode_r  <= win_b_s ? mode_b : mode_a;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          result   <= add_s[2:0];
          overflow <= add_s[3];
          valid    <= 1'b1;
          state_r  <= RESP;
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter; outputs are sampled 1 ns after each rising edge.
module tb_adder_arbiter;

  logic       clock;
  logic       reset;
  logic       req_a;
  logic [2:0] op1_a;
  logic [2:0] op2_a;
  logic       mode_a;
  logic       req_b;
  logic [2:0] op1_b;
  logic [2:0] op2_b;
  logic       mode_b;
  logic       grant_a;
  logic       grant_b;
  logic       valid;
  logic [2:0] result;
  logic       overflow;
  logic       owner;

  int         n_cmp;
  int         n_mis;
  logic [2:0] last_res;
  logic       last_ov;

  adder_arbiter dut (
    .clock    (clock),
    .reset    (reset),
    .req_a    (req_a),
    .op1_a    (op1_a),
    .op2_a    (op2_a),
    .mode_a   (mode_a),
    .req_b    (req_b),
    .op1_b    (op1_b),
    .op2_b    (op2_b),
    .mode_b   (mode_b),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .valid    (valid),
    .result   (result),
    .overflow (overflow),
    .owner    (owner)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected is packed as {grant_a, grant_b, valid, result[2:0], overflow, owner}.
  task automatic check(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {grant_a, grant_b, valid, result, overflow, owner};
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One isolated transaction for requester who (0 = A, 1 = B), starting in an IDLE cycle.
  task automatic txn(input string tag, input logic who, input logic [2:0] a,
                     input logic [2:0] b, input logic m, input logic [2:0] er,
                     input logic eo);
    if (who) begin
      req_b = 1'b1; op1_b = a; op2_b = b; mode_b = m;
    end else begin
      req_a = 1'b1; op1_a = a; op2_a = b; mode_a = m;
    end
    tick();
    check({tag, "_grant"}, {~who, who, 1'b0, last_res, last_ov, who});
    req_a = 1'b0; req_b = 1'b0;
    op1_a = 3'd0; op2_a = 3'd0; op1_b = 3'd0; op2_b = 3'd0;
    tick();
    check({tag, "_valid"}, {1'b0, 1'b0, 1'b1, er, eo, who});
    tick();
    check({tag, "_hold"}, {1'b0, 1'b0, 1'b0, er, eo, who});
    last_res = er;
    last_ov  = eo;
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    last_res = 3'd0; last_ov = 1'b0;
    reset = 1'b1;
    req_a = 1'b0; op1_a = 3'd0; op2_a = 3'd0; mode_a = 1'b0;
    req_b = 1'b0; op1_b = 3'd0; op2_b = 3'd0; mode_b = 1'b0;

    // Reset held two cycles with requests toggling.
    req_a = 1'b1; req_b = 1'b0;
    tick();
    check("rst_c1", 8'b0000_0000);
    req_a = 1'b0; req_b = 1'b1;
    tick();
    check("rst_c2", 8'b0000_0000);
    req_a = 1'b0; req_b = 1'b0;
    reset = 1'b0;
    tick();
    check("idle_after_rst", 8'b0000_0000);

    txn("a_3p2_u", 1'b0, 3'd3, 3'd2, 1'b0, 3'd5, 1'b0);
    txn("a_7p1_u", 1'b0, 3'd7, 3'd1, 1'b0, 3'd0, 1'b1);
    txn("a_3p1_s", 1'b0, 3'd3, 3'd1, 1'b1, 3'd4, 1'b1);
    txn("a_7p1_s", 1'b0, 3'd7, 3'd1, 1'b1, 3'd0, 1'b0);
    txn("b_4p4_s", 1'b1, 3'd4, 3'd4, 1'b1, 3'd0, 1'b1);

    // Late request: B rises while A is in EXEC.
    req_a = 1'b1; op1_a = 3'd2; op2_a = 3'd1; mode_a = 1'b0;
    tick();
    check("late_grant_a", {1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0});
    req_a = 1'b0;
    req_b = 1'b1; op1_b = 3'd1; op2_b = 3'd1; mode_b = 1'b0;
    tick();
    check("late_valid_a", {1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0});
    tick();
    check("late_resp", {1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0});
    tick();
    check("late_grant_b", {1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1});
    req_b = 1'b0;
    tick();
    check("late_valid_b", {1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1});
    tick();
    check("late_hold_b", {1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1});

    // Reset while A's transaction is in EXEC: aborted, everything cleared.
    req_a = 1'b1; op1_a = 3'd1; op2_a = 3'd2; mode_a = 1'b0;
    tick();
    check("abort_grant_a", {1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0});
    reset = 1'b1;
    req_b = 1'b1;
    tick();
    check("abort_rst", 8'b0000_0000);
    reset = 1'b0;

    // Contention from reset release: A wins first, then strict alternation.
    op1_a = 3'd1; op2_a = 3'd1; mode_a = 1'b0;
    op1_b = 3'd2; op2_b = 3'd2; mode_b = 1'b0;
    tick();
    check("cont_grant_a1", {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
    tick();
    check("cont_valid_a1", {1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
    tick();
    check("cont_resp_a1", {1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0});
    tick();
    check("cont_grant_b1", {1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1});
    tick();
    check("cont_valid_b1", {1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1});
    tick();
    check("cont_resp_b1", {1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1});
    tick();
    check("cont_grant_a2", {1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0});
    tick();
    check("cont_valid_a2", {1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
    tick();
    check("cont_resp_a2", {1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0});
    tick();
    check("cont_grant_b2", {1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1});
    req_a = 1'b0; req_b = 1'b0;
    tick();
    check("cont_valid_b2", {1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
